// File: rtl/orient_hist32.sv
// rtl/orient_hist32.sv - 32-bin orientation histogram with dominant-bin scan
// Optional feature macro: ORIENT_HIST_SAT_EN (bin accumulators clamp instead of wrapping)
module orient_hist32 #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [4:0]       s_dir,
  input  logic [MAG_W-1:0] s_mag,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [4:0]       m_bin,
  output logic [ACC_W-1:0] m_peak,
  output logic [CNT_W-1:0] m_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] hist_q [32];
  logic [ACC_W-1:0] hist_d [32];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [4:0]       best_bin_q, best_bin_d;
  logic [ACC_W-1:0] best_val_q, best_val_d;
  logic             m_valid_q, m_valid_d;
  logic [4:0]       m_bin_q, m_bin_d;
  logic [ACC_W-1:0] m_peak_q, m_peak_d;
  logic [CNT_W-1:0] m_count_q, m_count_d;

  // One extra bit on the sum exposes the carry-out used for clamping.
  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   bin_sum;
  logic [ACC_W-1:0] bin_new;
  logic [CNT_W-1:0] cnt_inc;
  logic [4:0]       cand_bin;
  logic [ACC_W-1:0] cand_val;

  // Bin update value, saturating counter increment and running-max candidate.
  always_comb begin
    mag_ext = (ACC_W+1)'(s_mag);
    bin_sum = {1'b0, hist_q[s_dir]} + mag_ext;
`ifdef ORIENT_HIST_SAT_EN
    bin_new = bin_sum[ACC_W] ? {ACC_W{1'b1}} : bin_sum[ACC_W-1:0];
`else
    bin_new = bin_sum[ACC_W-1:0];
`endif
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    // Strict compare so ties keep the lower index already held.
    if (hist_q[idx_q] > best_val_q) begin
      cand_bin = idx_q;
      cand_val = hist_q[idx_q];
    end else begin
      cand_bin = best_bin_q;
      cand_val = best_val_q;
    end
  end

  // Next-state and datapath updates for ACCUM / SCAN / OUT.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    best_bin_d = best_bin_q;
    best_val_d = best_val_q;
    m_valid_d  = m_valid_q;
    m_bin_d    = m_bin_q;
    m_peak_d   = m_peak_q;
    m_count_d  = m_count_q;
    case (state_q)
      ACCUM: begin
        if (s_valid) begin
          hist_d[s_dir] = bin_new;
          cnt_d         = cnt_inc;
          if (s_last) begin
            state_d    = SCAN;
            idx_d      = 5'd0;
            best_bin_d = 5'd0;
            best_val_d = '0;
          end
        end
      end
      SCAN: begin
        idx_d      = idx_q + 5'd1;
        best_bin_d = cand_bin;
        best_val_d = cand_val;
        if (idx_q == 5'd31) begin
          m_bin_d   = cand_bin;
          m_peak_d  = cand_val;
          m_count_d = cnt_q;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          for (int i = 0; i < 32; i++) hist_d[i] = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      for (int i = 0; i < 32; i++) hist_q[i] <= '0;
      cnt_q      <= '0;
      idx_q      <= 5'd0;
      best_bin_q <= 5'd0;
      best_val_q <= '0;
      m_valid_q  <= 1'b0;
      m_bin_q    <= 5'd0;
      m_peak_q   <= '0;
      m_count_q  <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      best_bin_q <= best_bin_d;
      best_val_q <= best_val_d;
      m_valid_q  <= m_valid_d;
      m_bin_q    <= m_bin_d;
      m_peak_q   <= m_peak_d;
      m_count_q  <= m_count_d;
    end
  end

  assign s_ready = (state_q == ACCUM);
  assign busy    = (state_q != ACCUM);
  assign m_valid = m_valid_q;
  assign m_bin   = m_bin_q;
  assign m_peak  = m_peak_q;
  assign m_count = m_count_q;

endmodule
